// File: rtl/arm_pipe_pkg.sv
// Shared types and helpers for the parametrised hazard controller.
// Scoreboard entries carry a fixed-width destination so the package stays parameter-free.
package arm_pipe_pkg;

   localparam int         MAX_REG_W = 8;
   localparam logic [2:0] FWD_RF    = 3'd0;

   typedef struct packed {
      logic                 valid;
      logic [MAX_REG_W-1:0] dest;
      logic                 wb_en;
      logic                 mem_r;
   } sb_entry_t;

   // Bits needed to encode a forwarding select up to DEPTH+1.
   function automatic int fwd_sel_width(input int depth);
      return $clog2(depth + 2);
   endfunction

endpackage

// File: rtl/pipe_scoreboard.sv
// DEPTH-entry shift register of in-flight destinations with hold/bubble control.
// Emits per-entry match vectors for both ID sources plus each entry's load flag.
module pipe_scoreboard
   import arm_pipe_pkg::*;
#(
   parameter int REG_W = 4,
   parameter int DEPTH = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_hold,
   input  logic             i_bubble,
   input  sb_entry_t        i_entry,
   input  logic [REG_W-1:0] i_src1,
   input  logic [REG_W-1:0] i_src2,
   output logic [DEPTH-1:0] o_match1,
   output logic [DEPTH-1:0] o_match2,
   output logic [DEPTH-1:0] o_load
);

   sb_entry_t            r_entry [DEPTH];
   sb_entry_t            w_head;
   logic [MAX_REG_W-1:0] w_src1;
   logic [MAX_REG_W-1:0] w_src2;

   assign w_src1 = MAX_REG_W'(i_src1);
   assign w_src2 = MAX_REG_W'(i_src2);
   assign w_head = i_bubble ? '0 : i_entry;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int k = 0; k < DEPTH; k++) r_entry[k] <= '0;
      end else if (!i_hold) begin
         r_entry[0] <= w_head;
         for (int k = 1; k < DEPTH; k++) r_entry[k] <= r_entry[k-1];
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < DEPTH; gi++) begin : g_match
         assign o_match1[gi] = r_entry[gi].valid & r_entry[gi].wb_en & (r_entry[gi].dest == w_src1);
         assign o_match2[gi] = r_entry[gi].valid & r_entry[gi].wb_en & (r_entry[gi].dest == w_src2);
         assign o_load[gi]   = r_entry[gi].mem_r;
      end
   endgenerate

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: freeze/flush/stall priority, registered EXE forwarding
// selects and saturating stall/flush cycle counters on top of the destination scoreboard.
module pipe_hazard_ctrl
   import arm_pipe_pkg::*;
#(
   parameter int REG_W  = 4,
   parameter int DEPTH  = 2,
   parameter int FWD_EN = 1,
   parameter int CNT_W  = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             id_valid,
   input  logic [REG_W-1:0] id_src1,
   input  logic [REG_W-1:0] id_src2,
   input  logic             id_two_src,
   input  logic [REG_W-1:0] id_dest,
   input  logic             id_wb_en,
   input  logic             id_mem_r,
   input  logic             branch_taken,
   input  logic             mem_busy,
   output logic             freeze,
   output logic             flush,
   output logic             stall_all,
   output logic [2:0]       fwd_sel_a,
   output logic [2:0]       fwd_sel_b,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   localparam int SEL_W = fwd_sel_width(DEPTH);

   logic [DEPTH-1:0] w_match1, w_match2, w_load;
   logic             w_hazard, w_flush, w_freeze, w_bubble;
   sb_entry_t        w_entry;
   logic [SEL_W-1:0] w_sel_a, w_sel_b, r_sel_a, r_sel_b;
   logic [CNT_W-1:0] r_stall_cnt, r_flush_cnt;

   pipe_scoreboard #(.REG_W(REG_W), .DEPTH(DEPTH)) u_sb (
      .clk      (clk),
      .rst      (rst),
      .i_hold   (mem_busy),
      .i_bubble (w_bubble),
      .i_entry  (w_entry),
      .i_src1   (id_src1),
      .i_src2   (id_src2),
      .o_match1 (w_match1),
      .o_match2 (w_match2),
      .o_load   (w_load)
   );

   function automatic logic [SEL_W-1:0] enc_lowest(input logic [DEPTH-1:0] m);
      enc_lowest = SEL_W'(FWD_RF);
      for (int k = DEPTH - 1; k >= 0; k--)
         if (m[k]) enc_lowest = SEL_W'(k + 2);
   endfunction

   // With forwarding only a load still in EXE cannot supply its result in time.
   always_comb begin
      if (FWD_EN != 0)
         w_hazard = w_load[0] & (w_match1[0] | (id_two_src & w_match2[0]));
      else
         w_hazard = (|w_match1) | (id_two_src & (|w_match2));
   end

   assign w_flush  = branch_taken & ~mem_busy;
   assign w_freeze = mem_busy | (id_valid & w_hazard & ~branch_taken);
   assign w_bubble = w_flush | w_hazard | ~id_valid;

   always_comb begin
      w_entry       = '0;
      w_entry.valid = 1'b1;
      w_entry.dest  = MAX_REG_W'(id_dest);
      w_entry.wb_en = id_wb_en;
      w_entry.mem_r = id_mem_r;
   end

   always_comb begin
      w_sel_a = '0;
      w_sel_b = '0;
      if (FWD_EN != 0 && !w_bubble) begin
         w_sel_a = enc_lowest(w_match1);
         if (id_two_src) w_sel_b = enc_lowest(w_match2);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_sel_a <= '0;
         r_sel_b <= '0;
      end else if (!mem_busy) begin
         r_sel_a <= w_sel_a;
         r_sel_b <= w_sel_b;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_stall_cnt <= '0;
         r_flush_cnt <= '0;
      end else begin
         if (w_freeze && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + CNT_W'(1);
         if (w_flush && (r_flush_cnt != '1))  r_flush_cnt <= r_flush_cnt + CNT_W'(1);
      end
   end

   assign freeze    = w_freeze;
   assign flush     = w_flush;
   assign stall_all = mem_busy;
   assign fwd_sel_a = 3'(r_sel_a);
   assign fwd_sel_b = 3'(r_sel_b);
   assign stall_cnt = r_stall_cnt;
   assign flush_cnt = r_flush_cnt;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench: dut_f forwards (DEPTH=2), dut_n has no forwarding and 2-bit counters.
// Both see the same stimulus; each step checks the instance it targets.
module tb_pipe_hazard_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       id_valid = 1'b0, id_two_src = 1'b0, id_wb_en = 1'b0, id_mem_r = 1'b0;
   logic [3:0] id_src1 = '0, id_src2 = '0, id_dest = '0;
   logic       branch_taken = 1'b0, mem_busy = 1'b0;

   logic        f_freeze, f_flush, f_stall_all;
   logic [2:0]  f_sel_a, f_sel_b;
   logic [31:0] f_stall_cnt, f_flush_cnt;
   logic        n_freeze, n_flush, n_stall_all;
   logic [2:0]  n_sel_a, n_sel_b;
   logic [1:0]  n_stall_cnt, n_flush_cnt;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   pipe_hazard_ctrl #(.REG_W(4), .DEPTH(2), .FWD_EN(1), .CNT_W(32)) dut_f (
      .clk(clk), .rst(rst), .id_valid(id_valid), .id_src1(id_src1), .id_src2(id_src2),
      .id_two_src(id_two_src), .id_dest(id_dest), .id_wb_en(id_wb_en), .id_mem_r(id_mem_r),
      .branch_taken(branch_taken), .mem_busy(mem_busy), .freeze(f_freeze), .flush(f_flush),
      .stall_all(f_stall_all), .fwd_sel_a(f_sel_a), .fwd_sel_b(f_sel_b),
      .stall_cnt(f_stall_cnt), .flush_cnt(f_flush_cnt)
   );

   pipe_hazard_ctrl #(.REG_W(4), .DEPTH(2), .FWD_EN(0), .CNT_W(2)) dut_n (
      .clk(clk), .rst(rst), .id_valid(id_valid), .id_src1(id_src1), .id_src2(id_src2),
      .id_two_src(id_two_src), .id_dest(id_dest), .id_wb_en(id_wb_en), .id_mem_r(id_mem_r),
      .branch_taken(branch_taken), .mem_busy(mem_busy), .freeze(n_freeze), .flush(n_flush),
      .stall_all(n_stall_all), .fwd_sel_a(n_sel_a), .fwd_sel_b(n_sel_b),
      .stall_cnt(n_stall_cnt), .flush_cnt(n_flush_cnt)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic id(input logic v, input logic [3:0] s1, input logic [3:0] s2, input logic two,
                     input logic [3:0] d, input logic wb, input logic mr);
      id_valid = v; id_src1 = s1; id_src2 = s2; id_two_src = two;
      id_dest = d; id_wb_en = wb; id_mem_r = mr;
   endtask

   task automatic nop();
      id(1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #2;
   endtask

   task automatic do_reset();
      rst = 1'b0; nop(); branch_taken = 1'b0; mem_busy = 1'b0;
      tick(); tick();
      rst = 1'b1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      // Power-up reset state
      nop();
      #3;
      chk("rst_freeze", 32'(f_freeze), 0);
      chk("rst_flush", 32'(f_flush), 0);
      chk("rst_stall_all", 32'(f_stall_all), 0);
      chk("rst_sel_a", 32'(f_sel_a), 0);
      chk("rst_stall_cnt", f_stall_cnt, 0);
      tick(); tick();
      rst = 1'b1;

      // Reset asserted mid-stream
      id(1, 4'd13, 4'd0, 0, 4'd4, 1, 1);            // LDR r4
      tick();
      id(1, 4'd4, 4'd0, 0, 4'd5, 1, 0);             // ADD r5,r4
      settle(); chk("mid_pre_freeze", 32'(f_freeze), 1);
      tick(); tick();
      settle();
      chk("mid_pre_sel_a", 32'(f_sel_a), 3);
      chk("mid_pre_stall_cnt", f_stall_cnt, 1);
      #1 rst = 1'b0;
      #1;
      chk("mid_rst_sel_a", 32'(f_sel_a), 0);
      chk("mid_rst_stall_cnt", f_stall_cnt, 0);
      chk("mid_rst_freeze", 32'(f_freeze), 0);
      tick();
      rst = 1'b1;
      id(1, 4'd5, 4'd4, 1, 4'd6, 1, 0);             // ADD r6,r5,r4 after release
      settle(); chk("post_rst_freeze", 32'(f_freeze), 0);
      tick(); nop(); settle();
      chk("post_rst_sel_a", 32'(f_sel_a), 0);
      chk("post_rst_sel_b", 32'(f_sel_b), 0);

      // Back-to-back ALU dependency forwards from stage 2, one gap forwards from stage 3
      do_reset();
      id(1, 4'd2, 4'd3, 1, 4'd1, 1, 0);             // ADD r1,r2,r3
      tick();
      id(1, 4'd1, 4'd3, 1, 4'd2, 1, 0);             // SUB r2,r1,r3
      settle(); chk("alu_dep_freeze", 32'(f_freeze), 0);
      tick(); nop(); settle();
      chk("fwd_adj_sel_a", 32'(f_sel_a), 2);
      chk("fwd_adj_sel_b", 32'(f_sel_b), 0);
      tick();
      id(1, 4'd2, 4'd3, 1, 4'd1, 1, 0);             // ADD r1
      tick();
      id(1, 4'd9, 4'd10, 1, 4'd8, 1, 0);            // AND r8,r9,r10
      tick();
      id(1, 4'd1, 4'd8, 1, 4'd2, 1, 0);             // SUB r2,r1,r8
      tick(); nop(); settle();
      chk("fwd_gap_sel_a", 32'(f_sel_a), 3);
      chk("fwd_gap_sel_b", 32'(f_sel_b), 2);

      // Load-use: one freeze cycle then forward from stage 3
      do_reset();
      id(1, 4'd13, 4'd0, 0, 4'd4, 1, 1);            // LDR r4
      tick();
      id(1, 4'd4, 4'd6, 1, 4'd5, 1, 0);             // ADD r5,r4,r6
      settle();
      chk("ldu_freeze1", 32'(f_freeze), 1);
      chk("ldu_flush", 32'(f_flush), 0);
      tick(); settle();
      chk("ldu_freeze2", 32'(f_freeze), 0);
      chk("ldu_bubble_sel_a", 32'(f_sel_a), 0);
      tick(); nop(); settle();
      chk("ldu_sel_a", 32'(f_sel_a), 3);
      chk("ldu_sel_b", 32'(f_sel_b), 0);
      chk("ldu_stall_cnt", f_stall_cnt, 1);

      // No forwarding: any RAW freezes until the producer retires
      do_reset();
      id(1, 4'd0, 4'd0, 0, 4'd7, 1, 0);             // MOV r7
      tick();
      id(1, 4'd7, 4'd0, 0, 4'd0, 0, 0);             // CMP r7
      settle(); chk("nofwd_freeze1", 32'(n_freeze), 1);
      tick(); settle(); chk("nofwd_freeze2", 32'(n_freeze), 1);
      tick(); settle();
      chk("nofwd_freeze3", 32'(n_freeze), 0);
      chk("nofwd_stall_cnt", 32'(n_stall_cnt), 2);
      tick(); settle(); chk("nofwd_sel_a", 32'(n_sel_a), 0);
      id(1, 4'd0, 4'd0, 0, 4'd7, 1, 0);             // MOV r7
      tick();
      id(1, 4'd3, 4'd7, 0, 4'd0, 0, 0);             // src2=r7 but unused
      settle(); chk("nofwd_src2_unused", 32'(n_freeze), 0);
      tick();
      id(1, 4'd3, 4'd7, 1, 4'd0, 0, 0);             // src2=r7 used, producer in stage 2
      settle(); chk("nofwd_src2_used", 32'(n_freeze), 1);
      tick(); settle(); chk("nofwd_src2_release", 32'(n_freeze), 0);
      tick();
      id(1, 4'd0, 4'd0, 0, 4'd7, 1, 0);             // MOV r7
      tick();
      id(1, 4'd7, 4'd0, 0, 4'd0, 0, 0);             // CMP r7, two more stalls
      tick(); tick(); settle();
      chk("nofwd_cnt_sat", 32'(n_stall_cnt), 3);

      // Branch taken overrides a pending load-use hazard
      do_reset();
      id(1, 4'd13, 4'd0, 0, 4'd4, 1, 1);            // LDR r4
      tick();
      id(1, 4'd4, 4'd0, 0, 4'd9, 1, 1);             // LDR r9,[r4] (wrong path)
      branch_taken = 1'b1;
      settle();
      chk("br_flush", 32'(f_flush), 1);
      chk("br_freeze", 32'(f_freeze), 0);
      tick();
      branch_taken = 1'b0;
      id(1, 4'd9, 4'd4, 1, 4'd5, 1, 0);             // ADD r5,r9,r4
      settle();
      chk("br_bubbled_freeze", 32'(f_freeze), 0);
      chk("br_flush_cnt", f_flush_cnt, 1);
      chk("br_stall_cnt", f_stall_cnt, 0);
      tick(); nop(); settle();
      chk("br_sel_a", 32'(f_sel_a), 0);
      chk("br_sel_b", 32'(f_sel_b), 3);

      // Memory stall with branch pending: hold everything, flush afterwards
      do_reset();
      id(1, 4'd2, 4'd3, 1, 4'd1, 1, 0);             // ADD r1
      tick();
      id(1, 4'd1, 4'd3, 1, 4'd2, 1, 0);             // SUB r2,r1,r3
      tick();
      id(1, 4'd2, 4'd1, 1, 4'd3, 1, 0);             // ORR r3,r2,r1
      mem_busy = 1'b1; branch_taken = 1'b1;
      for (int c = 0; c < 3; c++) begin
         settle();
         chk("mb_stall_all", 32'(f_stall_all), 1);
         chk("mb_flush", 32'(f_flush), 0);
         chk("mb_freeze", 32'(f_freeze), 1);
         chk("mb_sel_hold", 32'(f_sel_a), 2);
         tick();
      end
      mem_busy = 1'b0;
      settle();
      chk("mb_after_flush", 32'(f_flush), 1);
      chk("mb_after_stall_all", 32'(f_stall_all), 0);
      chk("mb_stall_cnt", f_stall_cnt, 3);
      chk("mb_flush_cnt_hold", f_flush_cnt, 0);
      tick();
      branch_taken = 1'b0;
      id(1, 4'd2, 4'd1, 1, 4'd4, 1, 0);             // EOR r4,r2,r1
      settle();
      chk("mb_flush_cnt", f_flush_cnt, 1);
      chk("mb_flushed_sel_a", 32'(f_sel_a), 0);
      tick(); nop(); settle();
      chk("mb_held_entry_sel_a", 32'(f_sel_a), 3);
      chk("mb_retired_sel_b", 32'(f_sel_b), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
